// File: rtl/btn_led_pkg.sv
// Shared types and constants for the button/LED controller.
// Press FSM states, display mode type, counter width and the LED pattern decoder.
package btn_led_pkg;

  localparam int CNT_W = 27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    BOOT = 2'd2
  } state_e;

  typedef logic [1:0] mode_t;
  localparam mode_t MODE_RST = 2'd0;

  // Pin levels {led1, led2, led3} (0 = lit) for a mode; cnt_hi is cnt[26:24].
  function automatic logic [2:0] led_pattern(input mode_t mode, input logic [2:0] cnt_hi);
    logic [2:0] pat;
    pat = 3'b111;
    case (mode)
      2'd0: pat = {~cnt_hi[0], ~cnt_hi[1], 1'b1};
      2'd1: pat = 3'b111;
      2'd2: pat = 3'b110;
      2'd3: begin
        case (cnt_hi[2:1])
          2'd0:    pat = 3'b011;
          2'd1:    pat = 3'b101;
          2'd2:    pat = 3'b110;
          default: pat = 3'b111;
        endcase
      end
      default: pat = 3'b111;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/btn_led_ctrl_if.sv
// Board-side signal bundle for btn_led_ctrl: raw button in, LEDs/boot request/mode out.
// master = the controller, slave = the board (button source, LED sink).
interface btn_led_ctrl_if;
  import btn_led_pkg::*;

  logic  btn_n;
  logic  led1;
  logic  led2;
  logic  led3;
  logic  rst_n;
  mode_t mode;

  modport master (input btn_n, output led1, output led2, output led3, output rst_n, output mode);
  modport slave  (output btn_n, input led1, input led2, input led3, input rst_n, input mode);

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debounce for an active-low button.
// pressed changes only after DEBOUNCE_CYCLES consecutive cycles of the opposite level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_n,
  output logic pressed
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync;
  logic [DB_W-1:0] db_cnt;
  logic            sync_press;

  assign sync_press = ~sync[1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer into one stage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync    <= 2'b11;
      pressed <= 1'b0;
      db_cnt  <= '0;
    end else begin
      sync <= {sync[0], btn_n};
      if (sync_press != pressed) begin
        if (db_cnt == DB_LAST) begin
          pressed <= sync_press;
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/btn_led_ctrl.sv
// Button-driven LED mode controller: short press cycles MODE, long press requests boot.
// Define BTN_LED_CTRL_BOOT_EN to compile in the BOOT state and RST_N assertion.
module btn_led_ctrl
  import btn_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 480000,
  parameter int LONG_PRESS_CYCLES = 96000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_N,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic       RST_N,
  output logic [1:0] MODE
);

  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

  logic              pressed;
  logic [CNT_W-1:0]  cnt;
  state_e            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  mode_t             mode, mode_nxt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .CLK     (CLK),
    .RST     (RST),
    .btn_n   (BTN_N),
    .pressed (pressed)
  );

  always_ff @(posedge CLK) begin
    if (RST) cnt <= '0;
    else     cnt <= cnt + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      hold_cnt <= '0;
      mode     <= MODE_RST;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      mode     <= mode_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    mode_nxt  = mode;
    case (state)
      IDLE: begin
        if (pressed) begin
          state_nxt = HELD;
          hold_nxt  = '0;
        end
      end
      HELD: begin
        if (!pressed) begin
          state_nxt = IDLE;
          mode_nxt  = mode + 1'b1;
        end else if (hold_cnt != HOLD_MAX) begin
          // Saturates at HOLD_MAX so a very long hold without boot support stays a short press.
          hold_nxt = hold_cnt + 1'b1;
`ifdef BTN_LED_CTRL_BOOT_EN
          if (hold_nxt == HOLD_MAX) state_nxt = BOOT;
`endif
        end
      end
      BOOT:    state_nxt = BOOT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      {LED1, LED2, LED3} <= 3'b111;
    end else if (state == BOOT) begin
      {LED1, LED2, LED3} <= 3'b000;
    end else begin
      {LED1, LED2, LED3} <= led_pattern(mode, cnt[CNT_W-1 -: 3]);
    end
  end

`ifdef BTN_LED_CTRL_BOOT_EN
  always_ff @(posedge CLK) begin
    if (RST) RST_N <= 1'b1;
    else     RST_N <= (state != BOOT);
  end
`else
  assign RST_N = 1'b1;
`endif

  assign MODE = mode;

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Directed self-checking bench for btn_led_ctrl with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=50.
// Press accepted 6 edges after BTN_N falls; MODE steps 7 edges after BTN_N rises.
module tb_btn_led_ctrl;
  import btn_led_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  btn_led_ctrl_if bus ();

  btn_led_ctrl #(
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (50)
  ) dut (
    .CLK   (clk),
    .RST   (rst),
    .BTN_N (bus.btn_n),
    .LED1  (bus.led1),
    .LED2  (bus.led2),
    .LED3  (bus.led3),
    .RST_N (bus.rst_n),
    .MODE  (bus.mode)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic short_press(input int hold);
    bus.btn_n = 1'b0;
    tick(hold);
    bus.btn_n = 1'b1;
    tick(12);
  endtask

  initial begin
    bus.btn_n = 1'b1;
    tick(3);
    check("rst_leds",  {29'd0, bus.led1, bus.led2, bus.led3}, 32'h7);
    check("rst_rstn",  32'(bus.rst_n), 32'd1);
    check("rst_mode",  32'(bus.mode), 32'd0);
    check("rst_cnt",   32'(dut.cnt), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    tick(1);
    check("cnt_first_inc", 32'(dut.cnt), 32'd1);

    // Glitch shorter than the debounce window
    bus.btn_n = 1'b0;
    tick(3);
    bus.btn_n = 1'b1;
    tick(10);
    check("glitch_pressed", 32'(dut.u_debounce.pressed), 32'd0);
    check("glitch_state",   32'(dut.state), 32'(IDLE));
    check("glitch_mode",    32'(bus.mode), 32'd0);
    check("glitch_leds",    {29'd0, bus.led1, bus.led2, bus.led3}, 32'h7);

    // Single short press with exact advance timing
    bus.btn_n = 1'b0;
    tick(6);
    check("press_accept", 32'(dut.u_debounce.pressed), 32'd1);
    tick(14);
    bus.btn_n = 1'b1;
    tick(6);
    check("mode_before_step", 32'(bus.mode), 32'd0);
    tick(1);
    check("mode_step", 32'(bus.mode), 32'd1);
    tick(10);
    check("mode_once",  32'(bus.mode), 32'd1);
    check("mode1_leds", {29'd0, bus.led1, bus.led2, bus.led3}, 32'h7);
    check("mode1_rstn", 32'(bus.rst_n), 32'd1);

    // Four presses from reset: 1, 2, 3, 0
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    short_press(20);
    check("seq_mode1", 32'(bus.mode), 32'd1);
    short_press(20);
    check("seq_mode2", 32'(bus.mode), 32'd2);
    check("mode2_leds", {29'd0, bus.led1, bus.led2, bus.led3}, 32'h6);
    short_press(20);
    check("seq_mode3", 32'(bus.mode), 32'd3);
    check("mode3_leds", {29'd0, bus.led1, bus.led2, bus.led3}, 32'h3);
    short_press(20);
    check("seq_mode0", 32'(bus.mode), 32'd0);
    check("mode0_leds", {29'd0, bus.led1, bus.led2, bus.led3}, 32'h7);

    // Long press: BOOT entered 57 edges after BTN_N falls, visible on 58
`ifdef BTN_LED_CTRL_BOOT_EN
    bus.btn_n = 1'b0;
    tick(57);
    check("rstn_before_boot", 32'(bus.rst_n), 32'd1);
    tick(1);
    check("boot_rstn", 32'(bus.rst_n), 32'd0);
    check("boot_leds", {29'd0, bus.led1, bus.led2, bus.led3}, 32'h0);
    tick(2);
    bus.btn_n = 1'b1;
    tick(12);
    check("boot_release_mode",  32'(bus.mode), 32'd0);
    check("boot_release_rstn",  32'(bus.rst_n), 32'd0);
    check("boot_release_state", 32'(dut.state), 32'(BOOT));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("bootrst_rstn", 32'(bus.rst_n), 32'd1);
    check("bootrst_mode", 32'(bus.mode), 32'd0);
    check("bootrst_leds", {29'd0, bus.led1, bus.led2, bus.led3}, 32'h7);
    check("bootrst_cnt",  32'(dut.cnt), 32'd0);
`else
    bus.btn_n = 1'b0;
    tick(60);
    check("long_rstn_held", 32'(bus.rst_n), 32'd1);
    check("long_state",     32'(dut.state), 32'(HELD));
    bus.btn_n = 1'b1;
    tick(6);
    check("long_mode_before", 32'(bus.mode), 32'd0);
    tick(1);
    check("long_mode_step", 32'(bus.mode), 32'd1);
    tick(5);
    check("long_rstn_after", 32'(bus.rst_n), 32'd1);
    check("long_mode_once",  32'(bus.mode), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
`endif

    // Reset mid-press: a still-held button becomes a fresh press
    bus.btn_n = 1'b0;
    tick(10);
    check("midpress_state", 32'(dut.state), 32'(HELD));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_state",   32'(dut.state), 32'(IDLE));
    check("midrst_pressed", 32'(dut.u_debounce.pressed), 32'd0);
    check("midrst_mode",    32'(bus.mode), 32'd0);
    tick(6);
    check("repress_accept", 32'(dut.u_debounce.pressed), 32'd1);
    tick(1);
    check("repress_state", 32'(dut.state), 32'(HELD));
    tick(10);
    bus.btn_n = 1'b1;
    tick(12);
    check("repress_mode", 32'(bus.mode), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_led_ctrl.md
BTN_LED_CTRL -- requirements
Module: btn_led_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DEBOUNCE_CYCLES, default 480000: cycles of stable synchronized button level needed to accept a level change.
REQ-003 Parameter LONG_PRESS_CYCLES, default 96000000: cycles of debounced press before a long press is recognized.
REQ-004 Ports SHALL be, in this order:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- BTN_N  in  1  raw button, active-low, asynchronous to CLK.
- LED1, LED2, LED3  out  1 each  active-low LEDs.
- RST_N  out  1  active-low bootloader-entry request.
- MODE  out  2  current display mode.

Function
REQ-005 BTN_N SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-006 Debounce: the debounced press level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles.
- Any intervening return to the old level SHALL clear the count.
REQ-007 A free-running 27-bit counter SHALL increment every cycle and wrap 2^27-1 -> 0.
REQ-008 Press FSM states SHALL be IDLE, HELD, BOOT.
- IDLE -> HELD on debounced press; the hold counter clears.
- HELD with debounced release before the hold count reaches LONG_PRESS_CYCLES: short press -> IDLE.
- HELD when the hold count reaches LONG_PRESS_CYCLES: -> BOOT.
- BOOT is terminal; only RST leaves it.
REQ-009 A short press SHALL advance MODE by 1, mod 4 (3 -> 0), in the cycle after the release is accepted.
- Exactly one advance per press.
REQ-010 LED outputs by MODE (in the table below, "on" means the pin is driven low):
- Mode 0: LED1 = ~cnt[24], LED2 = ~cnt[25], LED3 off.
- Mode 1: all off.
- Mode 2: LED3 on, others off.
- Mode 3: one LED on, selected by cnt[26:25]: 0 -> LED1, 1 -> LED2, 2 -> LED3, 3 -> none.
REQ-011 In BOOT, all three LEDs SHALL be on and RST_N SHALL be 0. The release that follows SHALL NOT change MODE.
REQ-012 All outputs SHALL be registered. LED and RST_N changes appear one cycle after the state/counter change that causes them.
REQ-013 Pulses on BTN_N shorter than DEBOUNCE_CYCLES SHALL cause no state, MODE or output change.

Reset
REQ-014 While RST=1 at a clock edge, all of the following SHALL hold:
- State = IDLE; MODE = 0; counter = 0; hold and debounce counts = 0.
- Synchronizer and debounced level = released.
- LED1..3 = 1; RST_N = 1.
REQ-015 RST asserted mid-press or in BOOT SHALL return the block to the REQ-014 state on the next edge.
- A button still held after reset is released SHALL be treated as a new press once debounced.

Configuration
REQ-016 Macro BTN_LED_CTRL_BOOT_EN:
- Defined: the BOOT state and RST_N assertion SHALL be compiled in.
- Undefined: reaching LONG_PRESS_CYCLES SHALL be ignored; the press ends as a short press on release, and RST_N SHALL be constant 1.

Structure
REQ-017 Package btn_led_pkg SHALL hold:
- the FSM state enum (IDLE, HELD, BOOT);
- the mode type (2-bit) and its reset value;
- the counter width constant (27).
REQ-018 Synchronizer plus debounce SHALL be sub-module btn_debounce, parameterized by DEBOUNCE_CYCLES, output the debounced press level, and reset with RST.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=50)
REQ-019 Scenario: BTN_N low 3 cycles then high -> MODE stays 0, FSM stays IDLE, outputs unchanged.
REQ-020 Scenario: press 20 cycles then release -> MODE 0 -> 1 exactly once; LED1..3 = 1,1,1; RST_N = 1.
REQ-021 Scenario: four short presses of 20 cycles each -> MODE goes 1, 2, 3, 0. In mode 2, LED3 = 0 and LED1 = LED2 = 1.
REQ-022 Scenario (macro defined): hold 60 debounced cycles -> RST_N = 0 and LED1..3 = 0. After release, MODE is unchanged and RST_N stays 0.
REQ-023 Scenario (macro undefined): hold 60 cycles then release -> RST_N stays 1 and MODE advances by 1.
REQ-024 Scenario: RST pulsed 1 cycle while in BOOT -> next cycle RST_N = 1, MODE = 0, LED1..3 = 1, counter = 0.
